// File: rtl/mux_arb_nto1.sv
// N-to-1 valid/ready multiplexer with a registered output stage.
// The channel is picked directly by `control` or by round-robin arbitration over the valid inputs.
module mux_arb_nto1 #(
    parameter int WIDTH = 32,
    parameter int N     = 16,
    parameter int SEL_W = 4
) (
    input  logic                 clk,
    input  logic                 rstb,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic                 mode,
    input  logic [SEL_W-1:0]     control,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SEL_W-1:0]     out_sel
);

    localparam int               SPAN  = 1 << SEL_W;
    localparam logic [SEL_W:0]   N_EXT = (SEL_W + 1)'(N);
    localparam logic [SEL_W-1:0] LAST  = SEL_W'(N - 1);

    logic [SPAN-1:0]  valid_pad;
    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W:0]   rr_idx;
    logic             rr_vld;
    logic [SEL_W-1:0] rr_grant;
    logic             grant_vld_p0;
    logic [SEL_W-1:0] grant_p0;
    logic             space_p0;
    logic             xfer_p0;
    logic [WIDTH-1:0] data_p0;

    // Valid vector padded to the full index range: indices >= N read as
    // not-valid, so an out-of-range control can never grant or index past N.
    always_comb begin
        valid_pad          = '0;
        valid_pad[N-1:0]   = in_valid;
    end

    always_comb begin
        rr_vld   = 1'b0;
        rr_grant = '0;
        rr_idx   = '0;
        for (int k = 1; k <= N; k++) begin
            rr_idx = {1'b0, rr_ptr} + (SEL_W + 1)'(k);
            if (rr_idx >= N_EXT) rr_idx = rr_idx - N_EXT;
            if (!rr_vld && valid_pad[rr_idx[SEL_W-1:0]]) begin
                rr_vld   = 1'b1;
                rr_grant = rr_idx[SEL_W-1:0];
            end
        end
    end

    // Stage p0: grant selection and handshake (combinational)
    always_comb begin
        if (mode) begin
            grant_vld_p0 = rr_vld;
            grant_p0     = rr_grant;
        end else begin
            grant_vld_p0 = valid_pad[control];
            grant_p0     = control;
        end
    end

    assign space_p0 = !out_valid || out_ready;
    assign xfer_p0  = rstb && space_p0 && grant_vld_p0;

    always_comb begin
        data_p0  = '0;
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_p0 == SEL_W'(i)) begin
                data_p0     = in_data[i*WIDTH +: WIDTH];
                in_ready[i] = xfer_p0;
            end
        end
    end

    // Stage p1: output register and arbitration pointer
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            rr_ptr    <= LAST;
        end else if (xfer_p0) begin
            out_valid <= 1'b1;
            out_data  <= data_p0;
            out_sel   <= grant_p0;
            rr_ptr    <= grant_p0;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_arb_nto1.sv
// Randomised and directed bench for mux_arb_nto1 (N=16 and N=5 instances)
// checked against a transaction-level reference model.
module tb_mux_arb_nto1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rstb;
    logic [511:0] d16;
    logic [159:0] d5;
    logic [15:0]  v16;
    logic [4:0]   v5;
    logic         m16, m5;
    logic [3:0]   c16, c5;
    logic         r16, r5;

    logic [15:0]  rdy16;
    logic [4:0]   rdy5;
    logic [31:0]  od16, od5;
    logic         ov16, ov5;
    logic [3:0]   os16, os5;

    mux_arb_nto1 #(.WIDTH(32), .N(16), .SEL_W(4)) dut16 (
        .clk(clk), .rstb(rstb), .in_data(d16), .in_valid(v16), .in_ready(rdy16),
        .mode(m16), .control(c16), .out_data(od16), .out_valid(ov16),
        .out_ready(r16), .out_sel(os16)
    );

    mux_arb_nto1 #(.WIDTH(32), .N(5), .SEL_W(4)) dut5 (
        .clk(clk), .rstb(rstb), .in_data(d5), .in_valid(v5), .in_ready(rdy5),
        .mode(m5), .control(c5), .out_data(od5), .out_valid(ov5),
        .out_ready(r5), .out_sel(os5)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state, index 0 = N16 instance, 1 = N5 instance
    bit          mv[2];
    logic [31:0] md[2];
    int          ms[2];
    int          mp[2];
    int          nch[2] = '{16, 5};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void ref_grant(input int n, input logic md_i, input logic [3:0] c,
                                      input logic [15:0] v, input int ptr,
                                      output bit gv, output int g);
        gv = 1'b0;
        g  = 0;
        if (!md_i) begin
            if (int'(c) < n && v[c]) begin
                gv = 1'b1;
                g  = int'(c);
            end
        end else begin
            for (int k = 1; k <= n; k++) begin
                int i;
                i = (ptr + k) % n;
                if (!gv && v[i[3:0]]) begin
                    gv = 1'b1;
                    g  = i;
                end
            end
        end
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mv[d] = 1'b0;
            md[d] = '0;
            ms[d] = 0;
            mp[d] = nch[d] - 1;
        end
    endtask

    task automatic check_out();
        chk("out_valid16", {63'b0, ov16}, {63'b0, mv[0]});
        chk("out_data16",  {32'b0, od16}, {32'b0, md[0]});
        chk("out_sel16",   {60'b0, os16}, 64'(ms[0]));
        chk("out_valid5",  {63'b0, ov5},  {63'b0, mv[1]});
        chk("out_data5",   {32'b0, od5},  {32'b0, md[1]});
        chk("out_sel5",    {60'b0, os5},  64'(ms[1]));
    endtask

    task automatic tick();
        bit          nv[2];
        logic [31:0] nd[2];
        int          ns[2];
        int          np[2];
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            bit           gv, sp, ordy, mdi;
            int           g;
            logic [15:0]  v, er, obs;
            logic [3:0]   c;
            logic [511:0] dd;
            v    = (d == 0) ? v16 : {11'b0, v5};
            dd   = (d == 0) ? d16 : {352'b0, d5};
            c    = (d == 0) ? c16 : c5;
            mdi  = (d == 0) ? m16 : m5;
            ordy = (d == 0) ? r16 : r5;
            obs  = (d == 0) ? rdy16 : {11'b0, rdy5};
            ref_grant(nch[d], mdi, c, v, mp[d], gv, g);
            sp = !mv[d] || ordy;
            er = '0;
            if (rstb && sp && gv) er[g[3:0]] = 1'b1;
            chk((d == 0) ? "in_ready16" : "in_ready5", {48'b0, obs}, {48'b0, er});
            nv[d] = mv[d]; nd[d] = md[d]; ns[d] = ms[d]; np[d] = mp[d];
            if (!rstb) begin
                nv[d] = 1'b0; nd[d] = '0; ns[d] = 0; np[d] = nch[d] - 1;
            end else if (sp && gv) begin
                nv[d] = 1'b1; nd[d] = dd[g*32 +: 32]; ns[d] = g; np[d] = g;
            end else if (ordy) begin
                nv[d] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            mv[d] = nv[d]; md[d] = nd[d]; ms[d] = ns[d]; mp[d] = np[d];
        end
        check_out();
    endtask

    task automatic async_reset();
        rstb = 1'b0;
        #1;
        model_reset();
        check_out();
        chk("rst_ready16", {48'b0, rdy16}, 64'd0);
        chk("rst_ready5",  {59'b0, rdy5},  64'd0);
        tick();
        rstb = 1'b1;
    endtask

    task automatic randomize_inputs();
        for (int i = 0; i < 16; i++) d16[i*32 +: 32] = $urandom;
        for (int i = 0; i < 5; i++)  d5[i*32 +: 32]  = $urandom;
        v16 = 16'($urandom);
        v5  = 5'($urandom);
        m16 = 1'($urandom);
        m5  = 1'($urandom);
        c16 = 4'($urandom);
        c5  = 4'($urandom_range(0, 7));
        r16 = ($urandom_range(0, 3) != 0);
        r5  = ($urandom_range(0, 3) != 0);
    endtask

    int rr_seq[4] = '{0, 5, 10, 15};

    initial begin
        rstb = 1'b0;
        d16 = '0; d5 = '0; v16 = '0; v5 = '0;
        m16 = 1'b0; m5 = 1'b0; c16 = '0; c5 = '0;
        r16 = 1'b1; r5 = 1'b1;
        #2;
        model_reset();
        check_out();
        chk("rst_ready16", {48'b0, rdy16}, 64'd0);
        tick();
        tick();
        rstb = 1'b1;
        repeat (3) tick();

        // Reset asserted while beats are flowing
        v16 = 16'hffff; m16 = 1'b1; v5 = 5'h1f; m5 = 1'b1;
        for (int i = 0; i < 16; i++) d16[i*32 +: 32] = 32'h1000 + i;
        tick();
        tick();
        async_reset();
        v16 = '0; v5 = '0;
        tick();

        // Direct sweep
        for (int i = 0; i < 16; i++) d16[i*32 +: 32] = i;
        v16 = 16'hffff; m16 = 1'b0; r16 = 1'b1;
        for (int c = 0; c < 16; c++) begin
            c16 = 4'(c);
            tick();
        end

        // Round-robin fairness over a sparse valid pattern
        m16 = 1'b1; v16 = 16'h8421;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("rr_seq", {60'b0, os16}, 64'(rr_seq[k % 4]));
        end

        // Back-pressure
        m16 = 1'b0; c16 = 4'd2; v16 = 16'h0004;
        d16[64 +: 32] = 32'hDEADBEEF;
        tick();
        r16 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 16; i++) d16[i*32 +: 32] = $urandom;
            v16 = 16'hffff; c16 = 4'($urandom);
            tick();
            chk("bp_hold", {32'b0, od16}, 64'hDEADBEEF);
        end
        r16 = 1'b1; c16 = 4'd2; v16 = 16'h0004;
        d16[64 +: 32] = 32'h12345678;
        tick();
        chk("bp_next", {32'b0, od16}, 64'h12345678);
        v16 = '0;
        tick();

        // Mode switch preserves the pointer
        m16 = 1'b1; v16 = 16'h0008;
        tick();
        m16 = 1'b0; c16 = 4'd3;
        tick();
        m16 = 1'b1; v16 = 16'hffff;
        tick();
        chk("mode_sw", {60'b0, os16}, 64'd4);
        v16 = '0;

        // N=5 boundary: out-of-range control, then wrap search
        for (int i = 0; i < 5; i++) d5[i*32 +: 32] = $urandom;
        v5 = 5'h1f; m5 = 1'b0; c5 = 4'd4; r5 = 1'b1;
        tick();
        c5 = 4'd7;
        tick();
        chk("oor_drain", {63'b0, ov5}, 64'd0);
        tick();
        m5 = 1'b1; v5 = 5'h10;
        tick();
        chk("wrap_sel", {60'b0, os5}, 64'd4);
        tick();
        chk("wrap_sel2", {60'b0, os5}, 64'd4);

        // Random traffic with occasional resets
        for (int k = 0; k < 400; k++) begin
            randomize_inputs();
            if ($urandom_range(0, 49) == 0) async_reset();
            else tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
